// File: rtl/audio_mem_ctrl.sv
// audio_mem_ctrl: records/plays 32-bit stereo samples as two 16-bit words in external SRAM.
module audio_mem_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_rec,
    input  logic        i_start_play,
    input  logic        i_stop,
    input  logic        record_audio_valid,
    input  logic [31:0] record_audio_data,
    output logic        record_audio_ready,
    output logic        play_audio_valid,
    output logic [31:0] play_audio_data,
    input  logic        play_audio_ready,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    input  logic [15:0] i_sram_rdata,
    output logic        o_sram_we_n,
    output logic        o_sram_oe_n,
    output logic [19:0] o_rec_end,
    output logic [2:0]  o_state
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC_WAIT   = 3'd1,
        REC_WR_HI  = 3'd2,
        REC_WR_LO  = 3'd3,
        PLAY_RD_HI = 3'd4,
        PLAY_RD_LO = 3'd5,
        PLAY_WAIT  = 3'd6
    } state_t;
    // The final word pair is never used, so a full recording ends here.
    localparam logic [19:0] LAST_END = 20'hFFFFE;
    state_t      state_q, state_d;
    logic [19:0] ptr_q, ptr_d, rec_end_q, rec_end_d;
    logic [31:0] rec_data_q, rec_data_d, play_data_q, play_data_d;
    logic        stop_pend_q, stop_pend_d;
    logic [19:0] ptr_inc1, ptr_inc2;
    assign ptr_inc1 = ptr_q + 20'd1;
    assign ptr_inc2 = ptr_q + 20'd2;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rec_end_q   <= '0;
            rec_data_q  <= '0;
            play_data_q <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rec_end_q   <= rec_end_d;
            rec_data_q  <= rec_data_d;
            play_data_q <= play_data_d;
            stop_pend_q <= stop_pend_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rec_end_d   = rec_end_q;
        rec_data_d  = rec_data_q;
        play_data_d = play_data_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            IDLE: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (i_start_rec) begin
                    state_d   = REC_WAIT;
                    ptr_d     = '0;
                    rec_end_d = '0;
                end else if (i_start_play && rec_end_q != '0) begin
                    state_d = PLAY_RD_HI;
                    ptr_d   = '0;
                end
            end
            REC_WAIT: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (record_audio_valid) begin
                    rec_data_d = record_audio_data;
                    state_d    = REC_WR_HI;
                end
            end
            REC_WR_HI: begin
                // A stop mid-sample is deferred so the sample completes.
                stop_pend_d = stop_pend_q | i_stop;
                state_d     = REC_WR_LO;
            end
            REC_WR_LO: begin
                ptr_d       = ptr_inc2;
                rec_end_d   = ptr_inc2;
                stop_pend_d = 1'b0;
                state_d     = (stop_pend_q || i_stop || ptr_inc2 == LAST_END) ? IDLE : REC_WAIT;
            end
            PLAY_RD_HI: begin
                play_data_d[31:16] = i_sram_rdata;
                state_d            = i_stop ? IDLE : PLAY_RD_LO;
            end
            PLAY_RD_LO: begin
                play_data_d[15:0] = i_sram_rdata;
                state_d           = i_stop ? IDLE : PLAY_WAIT;
            end
            PLAY_WAIT: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (play_audio_ready) begin
                    ptr_d   = ptr_inc2;
                    state_d = (ptr_inc2 == rec_end_q) ? IDLE : PLAY_RD_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign record_audio_ready = (state_q == REC_WAIT) && !i_stop;
    assign play_audio_valid   = (state_q == PLAY_WAIT);
    assign play_audio_data    = play_data_q;
    assign o_sram_we_n        = !(state_q == REC_WR_HI || state_q == REC_WR_LO);
    assign o_sram_oe_n        = !(state_q == PLAY_RD_HI || state_q == PLAY_RD_LO);
    assign o_sram_addr        = (state_q == REC_WR_HI || state_q == PLAY_RD_HI) ? ptr_q :
                                (state_q == REC_WR_LO || state_q == PLAY_RD_LO) ? ptr_inc1 : '0;
    assign o_sram_wdata       = (state_q == REC_WR_HI) ? rec_data_q[31:16] :
                                (state_q == REC_WR_LO) ? rec_data_q[15:0] : '0;
    assign o_rec_end          = rec_end_q;
    assign o_state            = state_q;
endmodule

// File: tb/tb_audio_mem_ctrl.sv
// tb_audio_mem_ctrl: directed record/play/stop/reset checks against a small SRAM model.
module tb_audio_mem_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_rec = 1'b0, start_play = 1'b0, stop = 1'b0;
    logic        rv = 1'b0, pr = 1'b0;
    logic [31:0] rd = '0;
    logic        rr, pv, we_n, oe_n;
    logic [31:0] pd;
    logic [19:0] addr, rec_end;
    logic [15:0] wdata, rdata;
    logic [2:0]  st;
    logic [15:0] mem [0:63];
    int          wr_hits [0:63] = '{default: 0};
    int          vectors = 0, miscompares = 0, overlap = 0;
    logic [15:0] exp_words [0:5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

    audio_mem_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_rec(start_rec), .i_start_play(start_play),
        .i_stop(stop), .record_audio_valid(rv), .record_audio_data(rd),
        .record_audio_ready(rr), .play_audio_valid(pv), .play_audio_data(pd),
        .play_audio_ready(pr), .o_sram_addr(addr), .o_sram_wdata(wdata),
        .i_sram_rdata(rdata), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
        .o_rec_end(rec_end), .o_state(st)
    );

    always #5 clk = ~clk;
    assign rdata = oe_n ? 16'h0 : mem[addr[5:0]];
    always @(posedge clk) begin
        if (!we_n) begin
            mem[addr[5:0]] <= wdata;
            wr_hits[addr[5:0]] = wr_hits[addr[5:0]] + 1;
        end
        if (!we_n && !oe_n) overlap = overlap + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rec_sample(input logic [31:0] d, input logic [19:0] a);
        rv = 1'b1; rd = d;
        @(negedge clk);
        rv = 1'b0;
        check("wr_hi_state", st, 32'd2);
        check("wr_hi_we", we_n, 32'd0);
        check("wr_hi_addr", addr, a);
        check("wr_hi_data", wdata, d[31:16]);
        @(negedge clk);
        check("wr_lo_state", st, 32'd3);
        check("wr_lo_addr", addr, a + 20'd1);
        check("wr_lo_data", wdata, d[15:0]);
        @(negedge clk);
        check("rec_wait_state", st, 32'd1);
        check("rec_end_step", rec_end, a + 20'd2);
        check("rec_we_off", we_n, 32'd1);
    endtask

    task automatic play_sample(input logic [31:0] exp, input logic [2:0] next_st);
        int n = 0;
        while (!pv && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("play_valid", pv, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("play_hold_data", pd, exp);
            check("play_hold_valid", pv, 32'd1);
        end
        @(negedge clk);
        check("play_data", pd, exp);
        pr = 1'b1;
        @(negedge clk);
        pr = 1'b0;
        check("play_next_state", st, next_st);
        check("play_valid_drop", pv, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", st, 32'd0);
        check("rst_play_valid", pv, 32'd0);
        check("rst_rec_ready", rr, 32'd0);
        check("rst_we_n", we_n, 32'd1);
        check("rst_oe_n", oe_n, 32'd1);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_rec_end", rec_end, 32'd0);
        check("rst_play_data", pd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_rec = 1'b1; stop = 1'b1;
        @(negedge clk);
        start_rec = 1'b0; stop = 1'b0;
        check("stop_beats_start", st, 32'd0);
        start_rec = 1'b1;
        @(negedge clk);
        start_rec = 1'b0;
        check("rec_start_state", st, 32'd1);
        check("rec_ready", rr, 32'd1);
        rec_sample(32'h11112222, 20'd0);
        rec_sample(32'h33334444, 20'd2);
        rec_sample(32'h55556666, 20'd4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("rec_stop_state", st, 32'd0);
        check("rec_end_final", rec_end, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("sram_word", mem[i], exp_words[i]);
            check("we_pulse_count", wr_hits[i], 32'd1);
        end
        start_play = 1'b1;
        @(negedge clk);
        start_play = 1'b0;
        check("play_rd_hi_state", st, 32'd4);
        check("play_oe_n", oe_n, 32'd0);
        check("play_addr", addr, 32'd0);
        play_sample(32'h11112222, 3'd4);
        play_sample(32'h33334444, 3'd4);
        play_sample(32'h55556666, 3'd0);
        start_rec = 1'b1; start_play = 1'b1;
        @(negedge clk);
        start_rec = 1'b0; start_play = 1'b0;
        check("rec_beats_play", st, 32'd1);
        rec_sample(32'hAAAABBBB, 20'd0);
        rv = 1'b1; rd = 32'hCCCCDDDD;
        @(negedge clk);
        rv = 1'b0;
        check("stop_wr_hi_state", st, 32'd2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_wr_lo_state", st, 32'd3);
        check("stop_wr_lo_addr", addr, 32'd3);
        @(negedge clk);
        check("stop_idle_state", st, 32'd0);
        check("stop_rec_end", rec_end, 32'd4);
        check("stop_word2", mem[2], 32'h0000CCCC);
        check("stop_word3", mem[3], 32'h0000DDDD);
        start_play = 1'b1;
        @(negedge clk);
        start_play = 1'b0;
        for (int n = 0; n < 20 && !pv; n++) @(negedge clk);
        check("pre_reset_valid", pv, 32'd1);
        check("pre_reset_data", pd, 32'hAAAABBBB);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", pv, 32'd0);
        check("async_rst_oe_n", oe_n, 32'd1);
        check("async_rst_rec_end", rec_end, 32'd0);
        check("async_rst_state", st, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_play = 1'b1;
        @(negedge clk);
        start_play = 1'b0;
        check("empty_play_state", st, 32'd0);
        repeat (3) @(negedge clk);
        check("empty_play_valid", pv, 32'd0);
        check("empty_play_state_late", st, 32'd0);
        check("we_oe_overlap", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
